// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the fetch-control stage.
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_RESET = 0;
endpackage

// File: rtl/inst_fetch_if.sv
// Control/status bundle between the decode/testbench side and the fetch stage.
interface inst_fetch_if #(
  parameter int A  = 10,
  parameter int CW = 16
);
  logic          Start;
  logic [A-1:0]  StartAddr;
  logic          Stall;
  logic          BranchEn;
  logic          BranchRel;
  logic [A-1:0]  BranchTarget;
  logic          Halt;
  logic [A-1:0]  InstAddress;
  logic          Running;
  logic          Done;
  logic [CW-1:0] CycleCount;

  modport master (
    output Start, StartAddr, Stall, BranchEn, BranchRel, BranchTarget, Halt,
    input  InstAddress, Running, Done, CycleCount
  );

  modport slave (
    input  Start, StartAddr, Stall, BranchEn, BranchRel, BranchTarget, Halt,
    output InstAddress, Running, Done, CycleCount
  );
endinterface

// File: rtl/inst_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr)                 r_count <= '0;
    else if (en && (r_count != '1)) r_count <= r_count + CW'(1);
  end

  assign count = r_count;
endmodule

// File: rtl/inst_fetch.sv
// PC / fetch control: IDLE -> RUN -> HALTED program sequencing, next-PC select
// (halt > stall > branch > increment) and a saturating RUN-cycle counter.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int A  = 10,
  parameter int CW = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);
  fetch_state_t  r_state, w_next_state;
  logic [A-1:0]  r_pc, w_next_pc, w_branch_pc;
  logic          r_running, r_done;
  logic          w_launch, w_in_run;
  logic [CW-1:0] w_cycle_count;

  assign w_in_run = (r_state == RUN);
  assign w_launch = !w_in_run && bus.Start;

  // A-bit add of the raw offset equals sign-extend-then-truncate.
  assign w_branch_pc = bus.BranchRel ? (r_pc + bus.BranchTarget) : bus.BranchTarget;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    case (r_state)
      IDLE, HALTED: begin
        if (bus.Start) begin
          w_next_state = RUN;
          w_next_pc    = bus.StartAddr;
        end
      end
      RUN: begin
        if (bus.Halt)        w_next_state = HALTED;
        else if (!bus.Stall) w_next_pc    = bus.BranchEn ? w_branch_pc : r_pc + A'(1);
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= A'(PC_RESET);
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_running <= (w_next_state == RUN);
      r_done    <= (w_next_state == HALTED);
    end
  end

  // Launch clears the count; every RUN cycle (stall and halt included) counts.
  sat_counter #(.CW(CW)) u_cycle_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (w_launch),
    .en    (w_in_run),
    .count (w_cycle_count)
  );

  assign bus.InstAddress = r_pc;
  assign bus.Running     = r_running;
  assign bus.Done        = r_done;
  assign bus.CycleCount  = w_cycle_count;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences,
// random traffic against a flag-based reference model, and a narrow-counter saturation run.
module tb_inst_fetch;
  logic clk;
  logic rst;
  logic rst_s;
  int   checks;
  int   errors;

  inst_fetch_if #(.A(10), .CW(16)) bus ();
  inst_fetch_if #(.A(10), .CW(4))  bus_s ();

  inst_fetch #(.A(10), .CW(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  inst_fetch #(.A(10), .CW(4)) dut_s (
    .Clk   (clk),
    .Reset (rst_s),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, s;
    logic [9:0] sa;
    logic       st, b, rl;
    logic [9:0] t;
    logic       h;
    logic [9:0] pc;
    logic       run, dn;
    logic [15:0] c;
  } vec_t;

  vec_t vt[$];

  // Reference model: running/done flags plus integer PC and count.
  bit m_run, m_done;
  int m_pc, m_cnt;

  function automatic vec_t v(logic r, logic s, logic [9:0] sa, logic st, logic b,
                             logic rl, logic [9:0] t, logic h, logic [9:0] pc,
                             logic run, logic dn, logic [15:0] c);
    vec_t x;
    x.r = r; x.s = s; x.sa = sa; x.st = st; x.b = b; x.rl = rl; x.t = t; x.h = h;
    x.pc = pc; x.run = run; x.dn = dn; x.c = c;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [9:0] pc, logic run, logic dn, logic [15:0] c);
    chk({nm, ".pc"},   32'(bus.InstAddress), 32'(pc));
    chk({nm, ".run"},  32'(bus.Running),     32'(run));
    chk({nm, ".done"}, 32'(bus.Done),        32'(dn));
    chk({nm, ".cnt"},  32'(bus.CycleCount),  32'(c));
  endtask

  task automatic drive(logic r, logic s, logic [9:0] sa, logic st, logic b,
                       logic rl, logic [9:0] t, logic h);
    rst              = r;
    bus.Start        = s;
    bus.StartAddr    = sa;
    bus.Stall        = st;
    bus.BranchEn     = b;
    bus.BranchRel    = rl;
    bus.BranchTarget = t;
    bus.Halt         = h;
  endtask

  task automatic model_step();
    int off;
    if (rst) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (bus.Start) begin
        m_run = 1; m_done = 0; m_pc = int'(bus.StartAddr); m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      off = int'(bus.BranchTarget);
      if (off >= 512) off -= 1024;
      if (bus.Halt) begin
        m_run = 0; m_done = 1;
      end else if (!bus.Stall) begin
        if (!bus.BranchEn)      m_pc = (m_pc + 1) % 1024;
        else if (bus.BranchRel) m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
        else                    m_pc = int'(bus.BranchTarget);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    rst_s = 1'b1;
    bus_s.Start = 0; bus_s.StartAddr = '0; bus_s.Stall = 0; bus_s.BranchEn = 0;
    bus_s.BranchRel = 0; bus_s.BranchTarget = '0; bus_s.Halt = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // r  s  sa      st b  rl t       h   pc      run dn cnt
    vt.push_back(v(1, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0));
    vt.push_back(v(0, 0, 10'h2AA, 1, 1, 0, 10'h155, 1, 10'h000, 0, 0, 0));
    vt.push_back(v(0, 1, 10'h010, 0, 0, 0, 10'h000, 0, 10'h010, 1, 0, 0));
    vt.push_back(v(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h011, 1, 0, 1));
    vt.push_back(v(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h012, 1, 0, 2));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 0, 10'h020, 0, 10'h020, 1, 0, 3));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 1, 10'h3FE, 0, 10'h01E, 1, 0, 4));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 0, 10'h100, 0, 10'h100, 1, 0, 5));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 0, 10'h040, 0, 10'h040, 1, 0, 6));
    vt.push_back(v(0, 0, 10'h000, 1, 1, 0, 10'h100, 0, 10'h040, 1, 0, 7));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 0, 10'h100, 1, 10'h040, 0, 1, 8));
    vt.push_back(v(0, 0, 10'h123, 1, 1, 0, 10'h100, 1, 10'h040, 0, 1, 8));
    vt.push_back(v(0, 1, 10'h3FF, 0, 0, 0, 10'h000, 0, 10'h3FF, 1, 0, 0));
    vt.push_back(v(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 1, 0, 1));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 0, 10'h3FF, 0, 10'h3FF, 1, 0, 2));
    vt.push_back(v(0, 0, 10'h000, 0, 1, 1, 10'h002, 0, 10'h001, 1, 0, 3));
    vt.push_back(v(0, 1, 10'h123, 0, 0, 0, 10'h000, 0, 10'h002, 1, 0, 4));
    vt.push_back(v(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h002, 0, 1, 5));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].s, vt[i].sa, vt[i].st, vt[i].b, vt[i].rl, vt[i].t, vt[i].h);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].run, vt[i].dn, vt[i].c);
    end

    // Relaunch from HALTED, 5 run cycles, halt: count 6 and frozen, then restart.
    drive(0, 1, 10'h000, 0, 0, 0, 0, 0); tick();
    chk_all("relaunch", 10'h000, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk_all("halt6", 10'h005, 0, 1, 6);
    drive(0, 0, 10'h0AA, 1, 1, 1, 10'h033, 1);
    for (int i = 0; i < 3; i++) tick();
    chk_all("frozen", 10'h005, 0, 1, 6);
    drive(0, 1, 10'h000, 0, 0, 0, 0, 0); tick();
    chk_all("restart", 10'h000, 1, 0, 0);

    // Reset mid-run with Start held: reset wins.
    drive(0, 0, 0, 0, 1, 0, 10'h055, 0); tick();
    chk_all("to55", 10'h055, 1, 0, 1);
    drive(1, 1, 10'h200, 0, 1, 0, 10'h111, 0); tick();
    chk_all("rst_mid", 10'h000, 0, 0, 0);
    tick();
    chk_all("rst_hold", 10'h000, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk_all("post_rst", 10'h000, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            10'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom), 10'($urandom), ($urandom_range(0, 19) == 0));
      tick();
      chk_all($sformatf("rnd%0d", i), 10'(m_pc), m_run, m_done, 16'(m_cnt));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // 4-bit counter instance: saturates at 15 and stays there through halt.
    @(posedge clk); #1;
    rst_s = 1'b0;
    bus_s.Start = 1'b1; bus_s.StartAddr = 10'h000;
    @(posedge clk); #1;
    bus_s.Start = 1'b0;
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;
    chk("sat.cnt", 32'(bus_s.CycleCount), 32'd15);
    chk("sat.pc",  32'(bus_s.InstAddress), 32'd20);
    bus_s.Halt = 1'b1;
    @(posedge clk); #1;
    bus_s.Halt = 1'b0;
    @(posedge clk); #1;
    chk("sat.halt_cnt", 32'(bus_s.CycleCount), 32'd15);
    chk("sat.done",     32'(bus_s.Done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
